exec_mem_unit: RTL and testbench
================================

# exec_mem_unit

Execute/memory-stage datapath of the rv32i single-cycle core. It combines the integer ALU, a 4 KiB byte-enabled data RAM and the load-result formatter (byte reader). It sits between the register file/sign-extender and the write-back mux. Load data is available in the same cycle as the address, as a single-cycle CPU requires.

## Interface
- No parameters; depth fixed at 1024 x 32-bit words (12-bit byte address).
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- alu_ctrl  in  4  ALU operation select.
- alu_src  in  1  0: operand B = src2, 1: operand B = sign_ext.
- src1  in  32  operand A (rs1).
- src2  in  32  rs2 value.
- sign_ext  in  32  sign-extended immediate.
- results  out  32  ALU result; also the data RAM byte address.
- zero  out  1  results == 0.
- res_last_bit  out  1  results[0].
- mem_read  in  1  read enable.
- mem_write  in  1  write enable.
- w_dat  in  32  store data, already lane-aligned.
- byte_enb  in  4  byte-lane mask, used for both store and load formatting.
- func3  in  3  load type.
- wb_data  out  32  formatted load result.
- valid  out  1  wb_data is legal for func3/byte_enb.
- debug_addr  in  12  debug byte address.
- debug_data  out  32  word at debug_addr[11:2].

## Operation
- Operand B = alu_src ? sign_ext : src2.
- alu_ctrl encodings:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA; shift amount = B[4:0].
  - 1000 SLT (signed), 1001 SLTU; result 32'd1 or 32'd0.
  - Any other code: results = 0.
- Arithmetic wraps modulo 2^32 with no overflow flag.
- RAM word index = results[11:2]. Bits [31:12] are ignored, so addresses wrap every 4 KiB. The write address is always {results[31:2],2'b00}.
- Write: on the clk edge with mem_write=1, each lane i with byte_enb[i]=1 gets w_dat[8i+7:8i]; other lanes are unchanged.
- Read: combinational. Raw word = mem[results[11:2]] when mem_read=1, else 0.
- Byte reader:
  - func3 000 LB: byte_enb one-hot; selected byte, sign-extended.
  - func3 100 LBU: byte_enb one-hot; selected byte, zero-extended.
  - func3 001 LH: byte_enb 0011 or 1100; selected halfword, sign-extended.
  - func3 101 LHU: byte_enb 0011 or 1100; selected halfword, zero-extended.
  - func3 010 LW: byte_enb 1111; whole word.
  - Any other func3/mask combination: wb_data = 0, valid = 0.
  - Legal combination: valid = 1, independent of mem_read.
- RAM contents are not cleared by reset. They are undefined (0 in simulation) until written.
- Read-during-write to the same word: the combinational read returns the old contents until the edge, then the new contents.

## Timing
- ALU, RAM read, byte reader and debug read are purely combinational; latency 0.
- Write latency is 1 edge: data is visible on reads right after the rising edge.
- While rst=1 (asynchronous, no clock needed):
  - Writes are blocked.
  - wb_data = 0, valid = 0, debug_data = 0.
  - ALU outputs still follow their inputs.
- Reset asserted mid-write: if rst is high at the edge, the write is dropped and memory keeps its old contents.
- mem_read and mem_write both high: the write happens at the edge; the read shows pre-edge data.

## Configuration
- DEBUG_PORT_EN:
  - Defined: debug_data returns the word at debug_addr[11:2] through an independent combinational read port.
  - Undefined: the debug port logic is removed, debug_data is tied to 0, and debug_addr is ignored.

## Test plan
- Reset: rst=1 with mem_read=1, func3=010, byte_enb=1111 -> wb_data=0, valid=0. Write pulse while in reset -> memory unchanged.
- ALU: src1=3, sign_ext=3, alu_src=1, ADD -> results=6, zero=0. src1=3, src2=3, SUB -> results=0, zero=1. SLT with src1=0xFFFFFFFF, src2=1 -> 1; SLTU with the same operands -> 0.
- Store/debug: results=0xC, w_dat=6, byte_enb=1111, mem_write=1 for one edge -> debug_data at 0xC = 00000006. The LW readback at 0xC also returns 6 with valid=1.
- Partial store: word 0x11223344, then byte_enb=0100 with w_dat=0x00AA0000 -> word reads 0x11AA3344.
- Loads from 0x000080FF:
  - LB, byte_enb=0010 -> 0xFFFFFF80.
  - LBU, same mask -> 0x00000080.
  - LH, byte_enb=0011 -> 0xFFFF80FF.
- Illegal/wrap: func3=011 -> valid=0, wb_data=0. Store at results=0x100C -> lands in word 0xC.

Source files
------------

// File: rtl/exec_mem_unit_if.sv
// Purpose : bundles the execute/memory-stage bus of the rv32i single-cycle core
//           (ALU operands/result, data RAM access, load formatting, debug port).
// Modports: master - drives operands, RAM controls and debug address (decode side)
//           slave  - exec_mem_unit view: consumes those, returns ALU/load/debug results
interface exec_mem_unit_if;
    // ALU operands and result
    logic [3:0]  alu_ctrl;
    logic        alu_src;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] sign_ext;
    logic [31:0] results;
    logic        zero;
    logic        res_last_bit;
    // Data RAM access and load formatting
    logic        mem_read;
    logic        mem_write;
    logic [31:0] w_dat;
    logic [3:0]  byte_enb;
    logic [2:0]  func3;
    logic [31:0] wb_data;
    logic        valid;
    // Debug read port
    logic [11:0] debug_addr;
    logic [31:0] debug_data;

    modport master (
        output alu_ctrl, alu_src, src1, src2, sign_ext,
        output mem_read, mem_write, w_dat, byte_enb, func3,
        output debug_addr,
        input  results, zero, res_last_bit,
        input  wb_data, valid,
        input  debug_data
    );

    modport slave (
        input  alu_ctrl, alu_src, src1, src2, sign_ext,
        input  mem_read, mem_write, w_dat, byte_enb, func3,
        input  debug_addr,
        output results, zero, res_last_bit,
        output wb_data, valid,
        output debug_data
    );
endinterface

// File: rtl/exec_mem_unit.sv
// Purpose : execute/memory stage of the rv32i single-cycle core: integer ALU,
//           4 KiB byte-enabled data RAM (1024 x 32, combinational read) and the
//           load-result byte reader.
// Ports   : i_clk  - system clock, rising edge
//           i_rst  - asynchronous active-high reset (blocks writes, zeroes load/debug outputs)
//           bus    - exec_mem_unit_if.slave: ALU operands/result/flags, RAM read/write
//                    controls, load formatting, debug address/data
// Config  : DEBUG_PORT_EN - when defined, debug_data reads the word at debug_addr[11:2]
//           through an independent read port; otherwise debug_data is tied to 0.
module exec_mem_unit (
    input  logic           i_clk,
    input  logic           i_rst,
    exec_mem_unit_if.slave bus
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned IDX_W  = 10;
    localparam int unsigned LANES  = 4;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [DATA_W-1:0] w_op_b;
    logic [4:0]        w_shamt;
    logic [DATA_W-1:0] w_result;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_raw;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_fmt;
    logic              w_fmt_valid;
    logic              w_unused;

    // Operand B mux and shift amount
    assign w_op_b  = bus.alu_src ? bus.sign_ext : bus.src2;
    assign w_shamt = w_op_b[4:0];

    // Integer ALU; unknown codes yield zero
    always_comb begin
        w_result = '0;
        case (bus.alu_ctrl)
            ALU_ADD:  w_result = bus.src1 + w_op_b;
            ALU_SUB:  w_result = bus.src1 - w_op_b;
            ALU_AND:  w_result = bus.src1 & w_op_b;
            ALU_OR:   w_result = bus.src1 | w_op_b;
            ALU_XOR:  w_result = bus.src1 ^ w_op_b;
            ALU_SLL:  w_result = bus.src1 << w_shamt;
            ALU_SRL:  w_result = bus.src1 >> w_shamt;
            ALU_SRA:  w_result = DATA_W'($signed(bus.src1) >>> w_shamt);
            ALU_SLT:  w_result = {31'd0, $signed(bus.src1) < $signed(w_op_b)};
            ALU_SLTU: w_result = {31'd0, bus.src1 < w_op_b};
            default:  w_result = '0;
        endcase
    end

    assign bus.results      = w_result;
    assign bus.zero         = (w_result == '0);
    assign bus.res_last_bit = w_result[0];

    // Word index ignores the upper address bits, so the RAM aliases every 4 KiB
    assign w_idx = w_result[11:2];

    // Byte-lane write; rst sampled at the edge drops the write
    always_ff @(posedge i_clk) begin
        if (!i_rst && bus.mem_write) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (bus.byte_enb[i]) begin
                    r_mem[w_idx][8*i +: 8] <= bus.w_dat[8*i +: 8];
                end
            end
        end
    end

    // Combinational read shows pre-edge contents during a same-cycle write
    assign w_raw = bus.mem_read ? r_mem[w_idx] : '0;

    // Byte reader: lane select by mask, sign/zero extension by func3[2]
    always_comb begin
        w_fmt       = '0;
        w_fmt_valid = 1'b0;
        w_byte      = '0;
        w_half      = '0;
        case (bus.func3)
            3'b000, 3'b100: begin
                w_fmt_valid = 1'b1;
                case (bus.byte_enb)
                    4'b0001: w_byte = w_raw[7:0];
                    4'b0010: w_byte = w_raw[15:8];
                    4'b0100: w_byte = w_raw[23:16];
                    4'b1000: w_byte = w_raw[31:24];
                    default: w_fmt_valid = 1'b0;
                endcase
                w_fmt = {{24{w_byte[7] & ~bus.func3[2]}}, w_byte};
            end
            3'b001, 3'b101: begin
                w_fmt_valid = 1'b1;
                case (bus.byte_enb)
                    4'b0011: w_half = w_raw[15:0];
                    4'b1100: w_half = w_raw[31:16];
                    default: w_fmt_valid = 1'b0;
                endcase
                w_fmt = {{16{w_half[15] & ~bus.func3[2]}}, w_half};
            end
            3'b010: begin
                w_fmt_valid = (bus.byte_enb == 4'b1111);
                w_fmt       = w_raw;
            end
            default: begin
                w_fmt_valid = 1'b0;
            end
        endcase
        // Illegal combinations and reset force a clean zero result
        if (!w_fmt_valid || i_rst) begin
            w_fmt       = '0;
            w_fmt_valid = 1'b0;
        end
    end

    assign bus.wb_data = w_fmt;
    assign bus.valid   = w_fmt_valid;

`ifdef DEBUG_PORT_EN
    // Independent debug read port, word-aligned
    assign bus.debug_data = i_rst ? '0 : r_mem[bus.debug_addr[11:2]];
    assign w_unused       = ^bus.debug_addr[1:0];
`else
    assign bus.debug_data = '0;
    assign w_unused       = ^bus.debug_addr;
`endif

endmodule

// File: tb/tb_exec_mem_unit.sv
// Purpose : directed self-checking bench for exec_mem_unit (ALU, RAM store/load,
//           byte reader, reset blocking, address wrap, debug port).
module tb_exec_mem_unit;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

`ifdef DEBUG_PORT_EN
    localparam bit DBG = 1'b1;
`else
    localparam bit DBG = 1'b0;
`endif

    exec_mem_unit_if bus ();

    exec_mem_unit u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    task automatic set_alu(input logic [3:0] ctrl, input logic src,
                           input logic [31:0] a, input logic [31:0] b2, input logic [31:0] imm);
        bus.alu_ctrl = ctrl;
        bus.alu_src  = src;
        bus.src1     = a;
        bus.src2     = b2;
        bus.sign_ext = imm;
    endtask

    task automatic set_addr(input logic [31:0] addr);
        set_alu(4'b0000, 1'b1, addr, 32'h0, 32'h0);
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        @(negedge clk);
        set_addr(addr);
        bus.w_dat     = data;
        bus.byte_enb  = be;
        bus.mem_write = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_write = 1'b0;
    endtask

    task automatic load(input logic [31:0] addr, input logic [2:0] f3, input logic [3:0] be);
        @(negedge clk);
        set_addr(addr);
        bus.mem_read = 1'b1;
        bus.func3    = f3;
        bus.byte_enb = be;
        #1;
    endtask

    task automatic alu(input logic [3:0] ctrl, input logic src,
                       input logic [31:0] a, input logic [31:0] b2, input logic [31:0] imm);
        @(negedge clk);
        set_alu(ctrl, src, a, b2, imm);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        set_alu(4'b0000, 1'b1, 32'd3, 32'd0, 32'd3);
        bus.mem_read   = 1'b1;
        bus.mem_write  = 1'b0;
        bus.w_dat      = '0;
        bus.byte_enb   = 4'b1111;
        bus.func3      = 3'b010;
        bus.debug_addr = 12'h00C;
        #2;

        // Reset: load/debug outputs forced low, ALU still live
        chk("rst_wb_data", bus.wb_data, 32'h0);
        chk("rst_valid", {31'd0, bus.valid}, 32'd0);
        chk("rst_debug", bus.debug_data, 32'h0);
        chk("rst_alu_add", bus.results, 32'd6);

        @(negedge clk);
        rst = 1'b0;

        // Write blocked while in reset
        store(32'h20, 32'h12345678, 4'b1111);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, bus.valid}, 32'd0);
        bus.w_dat     = 32'hDEADBEEF;
        bus.mem_write = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        load(32'h20, 3'b010, 4'b1111);
        chk("rst_write_blocked", bus.wb_data, 32'h12345678);

        // ALU
        alu(4'b0000, 1'b1, 32'd3, 32'd100, 32'd3);
        chk("add_imm", bus.results, 32'd6);
        chk("add_zero", {31'd0, bus.zero}, 32'd0);
        alu(4'b0001, 1'b0, 32'd3, 32'd3, 32'd9);
        chk("sub", bus.results, 32'd0);
        chk("sub_zero", {31'd0, bus.zero}, 32'd1);
        alu(4'b1000, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0);
        chk("slt", bus.results, 32'd1);
        alu(4'b1001, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0);
        chk("sltu", bus.results, 32'd0);
        alu(4'b0010, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0);
        chk("and", bus.results, 32'hF000F000);
        alu(4'b0011, 1'b0, 32'hF0F0F0F0, 32'h0F000000, 32'd0);
        chk("or", bus.results, 32'hFFF0F0F0);
        alu(4'b0100, 1'b0, 32'hFFFF0000, 32'hFF00FF00, 32'd0);
        chk("xor", bus.results, 32'h00FFFF00);
        alu(4'b0101, 1'b1, 32'd1, 32'd0, 32'h0000003F);
        chk("sll_shamt31", bus.results, 32'h80000000);
        alu(4'b0110, 1'b0, 32'h80000000, 32'd4, 32'd0);
        chk("srl", bus.results, 32'h08000000);
        alu(4'b0111, 1'b0, 32'h80000000, 32'd4, 32'd0);
        chk("sra", bus.results, 32'hF8000000);
        alu(4'b1111, 1'b0, 32'd5, 32'd5, 32'd0);
        chk("bad_ctrl", bus.results, 32'd0);
        alu(4'b0000, 1'b0, 32'd4, 32'd3, 32'd0);
        chk("res_last_bit", {31'd0, bus.res_last_bit}, 32'd1);

        // Store then debug and LW readback
        store(32'hC, 32'd6, 4'b1111);
        bus.debug_addr = 12'h00E;
        load(32'hC, 3'b010, 4'b1111);
        chk("debug_0xC", bus.debug_data, DBG ? 32'd6 : 32'd0);
        chk("lw_0xC", bus.wb_data, 32'd6);
        chk("lw_0xC_valid", {31'd0, bus.valid}, 32'd1);

        // Partial store
        store(32'h10, 32'h11223344, 4'b1111);
        store(32'h10, 32'h00AA0000, 4'b0100);
        load(32'h10, 3'b010, 4'b1111);
        chk("partial_store", bus.wb_data, 32'h11AA3344);

        // Byte reader
        store(32'h14, 32'h000080FF, 4'b1111);
        load(32'h14, 3'b000, 4'b0010);
        chk("lb_b1", bus.wb_data, 32'hFFFFFF80);
        load(32'h14, 3'b100, 4'b0010);
        chk("lbu_b1", bus.wb_data, 32'h00000080);
        load(32'h14, 3'b001, 4'b0011);
        chk("lh_lo", bus.wb_data, 32'hFFFF80FF);
        load(32'h14, 3'b101, 4'b0011);
        chk("lhu_lo", bus.wb_data, 32'h000080FF);
        load(32'h14, 3'b001, 4'b1100);
        chk("lh_hi", bus.wb_data, 32'h00000000);
        load(32'h14, 3'b000, 4'b0001);
        chk("lb_b0", bus.wb_data, 32'hFFFFFFFF);
        load(32'h14, 3'b100, 4'b0001);
        chk("lbu_b0", bus.wb_data, 32'h000000FF);

        // Illegal combinations and mem_read=0
        load(32'h14, 3'b011, 4'b1111);
        chk("bad_f3_valid", {31'd0, bus.valid}, 32'd0);
        chk("bad_f3_data", bus.wb_data, 32'd0);
        load(32'h14, 3'b000, 4'b0011);
        chk("lb_bad_mask", {31'd0, bus.valid}, 32'd0);
        load(32'h14, 3'b010, 4'b0111);
        chk("lw_bad_mask", {31'd0, bus.valid}, 32'd0);
        load(32'h14, 3'b010, 4'b1111);
        bus.mem_read = 1'b0;
        #1;
        chk("noread_data", bus.wb_data, 32'd0);
        chk("noread_valid", {31'd0, bus.valid}, 32'd1);

        // Address wrap at 4 KiB
        store(32'h100C, 32'hCAFEF00D, 4'b1111);
        load(32'hC, 3'b010, 4'b1111);
        chk("wrap_store", bus.wb_data, 32'hCAFEF00D);
        bus.debug_addr = 12'h00C;
        #1;
        chk("wrap_debug", bus.debug_data, DBG ? 32'hCAFEF00D : 32'd0);

        // Read during write: old data before the edge, new after
        store(32'h18, 32'hAAAA5555, 4'b1111);
        @(negedge clk);
        set_addr(32'h18);
        bus.mem_read  = 1'b1;
        bus.func3     = 3'b010;
        bus.byte_enb  = 4'b1111;
        bus.w_dat     = 32'h01020304;
        bus.mem_write = 1'b1;
        #1;
        chk("rdw_old", bus.wb_data, 32'hAAAA5555);
        @(posedge clk);
        #1;
        bus.mem_write = 1'b0;
        #1;
        chk("rdw_new", bus.wb_data, 32'h01020304);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
